fetch_stage32: RTL and testbench
================================

# fetch_stage32

Instruction-fetch stage of the 32-bit RISC-V core. It holds the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register. It also handles stall, redirect (branch/jump) and bubble insertion. It sits between the PC-redirect logic of EX and the decode stage.

## Interface
Parameters:
- `n`, 32, datapath and address width.
- `RESET_PC`, 32'h0000_0000, byte address of the first fetched instruction.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `stall`  input  1  decode cannot accept; hold PC and the IF/ID register.
- `redirect`  input  1  branch taken or jump; load `redirect_pc`.
- `redirect_pc`  input  n  byte target of the redirect.
- `inst_addr`  output  n  word index to instruction memory, equal to `{2'b00, pc[n-1:2]}`; combinational from the PC.
- `inst`  input  n  instruction returned combinationally by memory for `inst_addr`.
- `if_pc`  output  n  byte PC of the instruction held in IF/ID.
- `if_inst`  output  n  instruction held in IF/ID.
- `if_valid`  output  1  IF/ID holds a real instruction (0 = bubble).
- `misalign_err`  output  1  one-cycle pulse when a redirect target has `[1:0] != 0`.
- `fetch_count`  output  n  number of valid instructions accepted into IF/ID; wraps.

## Operation
- Reset values:
  - `pc` = `RESET_PC`
  - `if_pc` = 0
  - `if_inst` = 32'h0000_0013 (NOP, `addi x0,x0,0`)
  - `if_valid` = 0
  - `misalign_err` = 0
  - `fetch_count` = 0
- Priority per edge: `rst` > `redirect` > `stall` > normal advance.
- Normal advance (`stall`=0, `redirect`=0):
  - `if_pc` <= `pc`, `if_inst` <= `inst`, `if_valid` <= 1.
  - `pc` <= `pc` + 4.
  - `fetch_count` += 1.
- Stall: `pc`, `if_pc`, `if_inst`, `if_valid` and `fetch_count` all hold.
- Redirect (wins over stall):
  - `pc` <= `{redirect_pc[n-1:2], 2'b00}`.
  - IF/ID is loaded with a bubble: `if_valid` <= 0, `if_inst` <= NOP, `if_pc` <= 0.
  - `fetch_count` is unchanged.
- `misalign_err` <= `redirect & (redirect_pc[1:0] != 0)`; otherwise 0 on every edge.
- PC wrap: `pc` = 32'hFFFF_FFFC advances to 32'h0000_0000, with no flag.
- Memory covers 1024 words, so PCs alias every 4 KB. The fetch stage does not check this; it passes the full word index.
- `fetch_count` wraps from 32'hFFFF_FFFF to 0.
- Reset asserted mid-stall or mid-redirect: reset values win on that edge, and the pending redirect is discarded.

## Timing
- `inst_addr` follows `pc` combinationally, within the same cycle.
- Instruction latency is 1 cycle: an instruction at address A, presented when `pc` = A, appears on `if_inst`/`if_valid` after the next edge.
- First valid instruction: the edge following the first cycle with `rst`=0 loads IF/ID from `RESET_PC`.
- Redirect penalty is exactly 1 bubble cycle; the target instruction is valid on the second edge after `redirect`.
- Redirect and stall in the same cycle: the redirect is taken and the bubble is inserted regardless of `stall`. Decode must tolerate its register being overwritten by a bubble.
- `misalign_err` is high for exactly the one cycle following the redirect edge.

## Structure
- Shared include `riscv_defs.vh` holds:
  - `RV_NOP` (32'h0000_0013)
  - `RV_XLEN` (32)
  - the default `RESET_PC`
- Sub-module `pc_reg32` holds the PC register with its load/hold/increment mux. The IF/ID register, error pulse and counter live in `fetch_stage32`.
- The memory stays external; `fetch_stage32` connects to it through `inst_addr`/`inst`.

## Test plan
- Reset release, memory words 0..3 = 11,22,33,44:
  - `if_inst` = 11, 22, 33, 44 on four consecutive edges.
  - `if_pc` = 0, 4, 8, C.
  - `fetch_count` = 4.
- `stall` held 3 cycles while `if_inst`=22: outputs and `pc` frozen for 3 cycles; advancing resumes with 33.
- `redirect`=1, `redirect_pc`=0x40:
  - next edge: `if_valid`=0, `if_inst`=0x13.
  - following edge: `if_pc`=0x40, `if_valid`=1.
  - `fetch_count` does not count the bubble.
- `redirect` and `stall` together, target 0x80: redirect taken, bubble inserted, then 0x80 fetched once `stall` drops.
- `redirect_pc`=0x46: `misalign_err` pulses 1 cycle; PC becomes 0x44.
- `pc` forced to 0xFFFF_FFFC via redirect:
  - advance wraps to 0.
  - `inst_addr` = 0x3FFF_FFFF, then 0.
  - `rst` asserted mid-sequence restores all reset values on that edge.

Source files
------------

// File: rtl/fetch_stage32_pkg.sv
// Shared RISC-V constants for the fetch stage and its PC register.
package fetch_stage32_pkg;
  localparam int          RV_XLEN     = 32;
  localparam logic [31:0] RV_NOP      = 32'h0000_0013;
  localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/pc_reg32.sv
// Program counter register: reset, word-aligned load, hold, or +4 advance.
module pc_reg32
  import fetch_stage32_pkg::*;
#(
  parameter int           n        = RV_XLEN,
  parameter logic [n-1:0] RESET_PC = n'(RV_RESET_PC)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [n-1:0] load_pc,
  input  logic         advance,
  output logic [n-1:0] pc
);

  // Low two target bits are dropped; the misalignment is reported by the caller.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= {load_pc[n-1:2], 2'b00};
    end else if (advance) begin
      pc <= pc + n'(4);
    end
  end

endmodule

// File: rtl/fetch_stage32.sv
// Instruction-fetch stage: PC, word address to instruction memory, IF/ID
// register with stall hold, redirect bubble, misalignment pulse and counter.
module fetch_stage32
  import fetch_stage32_pkg::*;
#(
  parameter int           n        = RV_XLEN,
  parameter logic [n-1:0] RESET_PC = n'(RV_RESET_PC)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         redirect,
  input  logic [n-1:0] redirect_pc,
  output logic [n-1:0] inst_addr,
  input  logic [n-1:0] inst,
  output logic [n-1:0] if_pc,
  output logic [n-1:0] if_inst,
  output logic         if_valid,
  output logic         misalign_err,
  output logic [n-1:0] fetch_count
);

  // Handshake: IF/ID offers (if_pc, if_inst) with if_valid; decode signals
  // "not ready" by raising stall, which freezes the PC and IF/ID for that
  // edge. A redirect overrides stall and overwrites IF/ID with a bubble.

  logic [n-1:0] pc;
  logic         advance;

  assign advance   = !redirect && !stall;
  assign inst_addr = {2'b00, pc[n-1:2]};

  pc_reg32 #(
    .n        (n),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (redirect),
    .load_pc (redirect_pc),
    .advance (advance),
    .pc      (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      if_pc        <= '0;
      if_inst      <= n'(RV_NOP);
      if_valid     <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      misalign_err <= redirect && (redirect_pc[1:0] != 2'b00);
      if (redirect) begin
        if_pc    <= '0;
        if_inst  <= n'(RV_NOP);
        if_valid <= 1'b0;
      end else if (!stall) begin
        if_pc       <= pc;
        if_inst     <= inst;
        if_valid    <= 1'b1;
        fetch_count <= fetch_count + n'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage32.sv
// Randomized and directed bench for fetch_stage32 against a behavioural model.
module tb_fetch_stage32;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc, inst_addr, inst, if_pc, if_inst, fetch_count;
  logic        if_valid, misalign_err;

  logic [31:0] mem [1024];
  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  logic [31:0] m_pc, m_if_pc, m_if_inst, m_count;
  logic        m_if_valid, m_mis;

  always #5 clk = ~clk;

  assign inst = mem[inst_addr[9:0]];

  fetch_stage32 dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .inst_addr    (inst_addr),
    .inst         (inst),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_valid     (if_valid),
    .misalign_err (misalign_err),
    .fetch_count  (fetch_count)
  );

  logic [161:0] dut_vec;
  assign dut_vec = {inst_addr, if_pc, if_inst, if_valid, misalign_err, fetch_count, 32'h0};

  function automatic logic [161:0] model_vec();
    return {m_pc / 32'd4, m_if_pc, m_if_inst, m_if_valid, m_mis, m_count, 32'h0};
  endfunction

  // Architectural rules: reset, then redirect, then stall, then advance.
  task automatic model_edge(input logic r, s, d, input logic [31:0] t);
    if (r) begin
      m_pc = 32'h0; m_if_pc = 32'h0; m_if_inst = 32'h13; m_if_valid = 1'b0;
      m_mis = 1'b0; m_count = 32'h0;
    end else if (d) begin
      m_mis = (t % 4) != 0;
      m_pc = t - (t % 4);
      m_if_pc = 32'h0; m_if_inst = 32'h13; m_if_valid = 1'b0;
    end else begin
      m_mis = 1'b0;
      if (!s) begin
        m_if_pc = m_pc; m_if_inst = mem[(m_pc / 4) % 1024]; m_if_valid = 1'b1;
        m_pc = m_pc + 4; m_count = m_count + 1;
      end
    end
  endtask

  task automatic step(input logic r, s, d, input logic [31:0] t);
    rst = r; stall = s; redirect = d; redirect_pc = t;
    @(posedge clk);
    model_edge(r, s, d, t);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h44);
    n_total++;
    if (if_valid !== 1'b0 || if_inst !== 32'h13 || if_pc !== 32'h0 ||
        fetch_count !== 32'h0 || misalign_err !== 1'b0 || inst_addr !== 32'h0)
      $display("FAIL reset: got pc=%h inst=%h v=%b cnt=%h mis=%b addr=%h",
               if_pc, if_inst, if_valid, fetch_count, misalign_err, inst_addr);
    else n_pass++;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_inst [4];
    exp_inst[0] = 32'd11; exp_inst[1] = 32'd22; exp_inst[2] = 32'd33; exp_inst[3] = 32'd44;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      n_total++;
      if (if_inst !== exp_inst[i] || if_pc !== 32'(4 * i) || if_valid !== 1'b1)
        $display("FAIL seq[%0d]: got inst=%0d pc=%h v=%b want inst=%0d pc=%h v=1",
                 i, if_inst, if_pc, if_valid, exp_inst[i], 4 * i);
      else n_pass++;
    end
    n_total++;
    if (fetch_count !== 32'd4) $display("FAIL seq_count: got %0d want 4", fetch_count);
    else n_pass++;
  endtask

  task automatic test_stall();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      n_total++;
      if (if_inst !== 32'd22 || if_pc !== 32'h4 || inst_addr !== 32'h2 || fetch_count !== 32'd2)
        $display("FAIL stall[%0d]: got inst=%0d pc=%h addr=%h cnt=%0d want 22/4/2/2",
                 i, if_inst, if_pc, inst_addr, fetch_count);
      else n_pass++;
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_total++;
    if (if_inst !== 32'd33 || if_pc !== 32'h8)
      $display("FAIL stall_resume: got inst=%0d pc=%h want 33/8", if_inst, if_pc);
    else n_pass++;
  endtask

  task automatic test_redirect();
    logic [31:0] cnt0;
    cnt0 = m_count;
    step(1'b0, 1'b0, 1'b1, 32'h40);
    n_total++;
    if (if_valid !== 1'b0 || if_inst !== 32'h13 || fetch_count !== cnt0 || misalign_err !== 1'b0)
      $display("FAIL redir_bubble: got v=%b inst=%h cnt=%0d mis=%b want 0/13/%0d/0",
               if_valid, if_inst, fetch_count, misalign_err, cnt0);
    else n_pass++;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_total++;
    if (if_pc !== 32'h40 || if_valid !== 1'b1 || if_inst !== mem[16] || fetch_count !== cnt0 + 1)
      $display("FAIL redir_target: got pc=%h v=%b inst=%h cnt=%0d want 40/1/%h/%0d",
               if_pc, if_valid, if_inst, fetch_count, mem[16], cnt0 + 1);
    else n_pass++;
  endtask

  task automatic test_redirect_stall();
    step(1'b0, 1'b1, 1'b1, 32'h80);
    n_total++;
    if (if_valid !== 1'b0 || if_inst !== 32'h13 || inst_addr !== 32'h20)
      $display("FAIL redir_stall: got v=%b inst=%h addr=%h want 0/13/20",
               if_valid, if_inst, inst_addr);
    else n_pass++;
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_total++;
    if (if_pc !== 32'h80 || if_valid !== 1'b1 || if_inst !== mem[32])
      $display("FAIL redir_stall_target: got pc=%h v=%b inst=%h want 80/1/%h",
               if_pc, if_valid, if_inst, mem[32]);
    else n_pass++;
  endtask

  task automatic test_misalign();
    step(1'b0, 1'b0, 1'b1, 32'h46);
    n_total++;
    if (misalign_err !== 1'b1 || inst_addr !== 32'h11)
      $display("FAIL misalign: got mis=%b addr=%h want 1/11", misalign_err, inst_addr);
    else n_pass++;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_total++;
    if (misalign_err !== 1'b0 || if_pc !== 32'h44)
      $display("FAIL misalign_clear: got mis=%b pc=%h want 0/44", misalign_err, if_pc);
    else n_pass++;
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    n_total++;
    if (inst_addr !== 32'h3FFF_FFFF) $display("FAIL wrap_addr_hi: got %h want 3fffffff", inst_addr);
    else n_pass++;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_total++;
    if (inst_addr !== 32'h0 || if_pc !== 32'hFFFF_FFFC || if_inst !== mem[1023])
      $display("FAIL wrap: got addr=%h pc=%h inst=%h want 0/fffffffc/%h",
               inst_addr, if_pc, if_inst, mem[1023]);
    else n_pass++;
    step(1'b1, 1'b1, 1'b1, 32'h100);
    n_total++;
    if (if_valid !== 1'b0 || if_inst !== 32'h13 || if_pc !== 32'h0 ||
        fetch_count !== 32'h0 || inst_addr !== 32'h0 || misalign_err !== 1'b0)
      $display("FAIL wrap_reset: got pc=%h inst=%h v=%b cnt=%h addr=%h mis=%b",
               if_pc, if_inst, if_valid, fetch_count, inst_addr, misalign_err);
    else n_pass++;
  endtask

  task automatic test_random();
    logic r, s, d;
    logic [31:0] t;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 6) == 0);
      t = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4095));
      step(r, s, d, t);
      n_total++;
      if (dut_vec !== model_vec())
        $display("FAIL random[%0d]: got %h want %h", i, dut_vec, model_vec());
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33; mem[3] = 32'd44;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_misalign();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
